// File: rtl/param_est_dense_accum.sv
// param_est_dense_accum: sums N_TERMS products per neuron, adds bias, rescales, applies ReLU and saturation.
// Optional: define PARAM_EST_ACC_ROUND_EN for round-half-up rescaling instead of floor truncation.
`default_nettype none

module param_est_dense_accum #(
  parameter int PROD_W  = 22,
  parameter int N_TERMS = 8,
  parameter int BIAS_W  = 16,
  parameter int SHIFT   = 6,
  parameter int OUT_W   = 16,
  parameter int ACC_W   = 27
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [BIAS_W-1:0] bias,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sat,
  output logic              busy
);

  localparam int CNT_W = $clog2(N_TERMS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);
  localparam logic [OUT_W-1:0] OUT_MAX = '1;

`ifdef PARAM_EST_ACC_ROUND_EN
  // Half-LSB addend is folded into the first-term load so rounding costs no extra cycle.
  localparam logic signed [ACC_W-1:0] RND = ACC_W'((1 << SHIFT) >> 1);
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif

  generate
    if ((ACC_W < PROD_W + $clog2(N_TERMS) + 2) || (ACC_W < BIAS_W + SHIFT + 1) ||
        (ACC_W <= OUT_W) || (N_TERMS < 2)) begin : g_param_check
      $error("param_est_dense_accum: ACC_W too narrow or N_TERMS < 2");
    end
  endgenerate

  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] r;
  logic                    last;
  logic                    beat;
  logic                    clip_hi;

  assign last       = (cnt == LAST);
  assign prod_ready = !(last && out_valid && !out_ready);
  assign beat       = prod_valid && prod_ready;
  assign busy       = (cnt != '0);

  assign prod_ext = ACC_W'(prod_data);
  assign bias_ext = ACC_W'($signed(bias)) <<< SHIFT;
  assign sum      = acc + prod_ext;
  assign r        = sum >>> SHIFT;
  assign clip_hi  = |r[ACC_W-1:OUT_W];

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (beat) begin
        cnt <= last ? '0 : cnt + CNT_W'(1);
        acc <= (cnt == '0) ? (bias_ext + RND + prod_ext) : sum;
      end
      // A final beat loads a fresh result even when the old one is handed off this cycle.
      if (beat && last) begin
        out_valid <= 1'b1;
        if (r[ACC_W-1]) begin
          out_data <= '0;
          out_sat  <= 1'b0;
        end else if (clip_hi) begin
          out_data <= OUT_MAX;
          out_sat  <= 1'b1;
        end else begin
          out_data <= r[OUT_W-1:0];
          out_sat  <= 1'b0;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_param_est_dense_accum.sv
// tb_param_est_dense_accum: directed plus randomized bench with an arithmetic reference model.
`default_nettype none

module tb_param_est_dense_accum;

  localparam int PROD_W  = 22;
  localparam int N_TERMS = 8;
  localparam int BIAS_W  = 16;
  localparam int SHIFT   = 6;
  localparam int OUT_W   = 16;
  localparam int ACC_W   = 27;
`ifdef PARAM_EST_ACC_ROUND_EN
  localparam longint RND_ADD = longint'(1) << (SHIFT - 1);
  localparam longint RND_EXP = 2;
`else
  localparam longint RND_ADD = 0;
  localparam longint RND_EXP = 1;
`endif
  localparam longint OUT_MAX = (longint'(1) << OUT_W) - 1;

  logic              clk;
  logic              ap_rst;
  logic [PROD_W-1:0] prod_data;
  logic              prod_valid;
  logic              prod_ready;
  logic [BIAS_W-1:0] bias;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sat;
  logic              busy;

  param_est_dense_accum #(
    .PROD_W(PROD_W), .N_TERMS(N_TERMS), .BIAS_W(BIAS_W),
    .SHIFT(SHIFT), .OUT_W(OUT_W), .ACC_W(ACC_W)
  ) dut (
    .ap_clk(clk), .ap_rst(ap_rst),
    .prod_data(prod_data), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .bias(bias),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sat(out_sat), .busy(busy)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  bit     rdy_rand = 0;
  int     terms = 0;
  longint total = 0;
  longint exp_d[$];
  longint exp_s[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: keeps the running neuron sum as a plain integer and derives the
  // expected activation from the floor/round, ReLU and clip rules.
  always @(negedge clk) begin
    if (ap_rst) begin
      terms = 0;
      total = 0;
      exp_d.delete();
      exp_s.delete();
    end else begin
      check_val("out_valid", out_valid, longint'(exp_d.size() != 0));
      check_val("busy", busy, longint'(terms != 0));
      check_val("prod_ready", prod_ready,
                longint'(!(terms == N_TERMS - 1 && exp_d.size() != 0 && !out_ready)));
      if (out_valid && out_ready && exp_d.size() != 0) begin
        check_val("out_data", out_data, exp_d.pop_front());
        check_val("out_sat", out_sat, exp_s.pop_front());
      end
      if (prod_valid && prod_ready) begin
        if (terms == 0) total = longint'($signed(bias)) * (longint'(1) << SHIFT) + RND_ADD;
        total += longint'(prod_data);
        terms++;
        if (terms == N_TERMS) begin
          longint r;
          r = total >>> SHIFT;
          if (r < 0) begin
            exp_d.push_back(0);       exp_s.push_back(0);
          end else if (r > OUT_MAX) begin
            exp_d.push_back(OUT_MAX); exp_s.push_back(1);
          end else begin
            exp_d.push_back(r);       exp_s.push_back(0);
          end
          terms = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and returns at the cycle after it was accepted.
  task automatic send_beat(input logic [PROD_W-1:0] p, input logic [BIAS_W-1:0] b);
    bit ok;
    int n;
    prod_valid = 1'b1;
    prod_data  = p;
    bias       = b;
    n = 0;
    forever begin
      @(negedge clk);
      ok = prod_ready;
      cycle();
      if (ok) break;
      n++;
      if (n > 100) begin
        check_val("beat_timeout", 0, 1);
        break;
      end
    end
    prod_valid = 1'b0;
  endtask

  task automatic send_const(input logic [BIAS_W-1:0] b, input logic [PROD_W-1:0] p);
    for (int i = 0; i < N_TERMS; i++) send_beat(p, b);
  endtask

  task automatic check_result(input string tag, input longint d, input longint s);
    check_val({tag, "_valid"}, out_valid, 1);
    check_val({tag, "_data"}, out_data, d);
    check_val({tag, "_sat"}, out_sat, s);
  endtask

  initial begin
    ap_rst     = 1'b1;
    prod_valid = 1'b0;
    prod_data  = '0;
    bias       = '0;
    out_ready  = 1'b1;
    cycle();
    cycle();
    check_val("rst_valid", out_valid, 0);
    check_val("rst_data", out_data, 0);
    check_val("rst_sat", out_sat, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ready", prod_ready, 1);
    ap_rst = 1'b0;
    cycle();

    send_const(16'd0, 22'd64);
    check_result("basic", 8, 0);
    cycle();

    send_const(16'hFF9C, 22'd64);
    check_result("relu", 0, 0);
    cycle();

    send_const(16'd0, 22'h3FFFFF);
    check_result("sat", OUT_MAX, 1);
    cycle();

    send_const(16'd0, 22'd12);
    check_result("round", RND_EXP, 0);
    cycle();

    // Backpressure: the pending result holds while only the final beat of the next neuron stalls.
    send_const(16'd0, 22'd64);
    out_ready = 1'b0;
    check_result("bp_first", 8, 0);
    for (int i = 0; i < N_TERMS - 1; i++) send_beat(22'd128, 16'd0);
    prod_valid = 1'b1;
    prod_data  = 22'd128;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_stall", prod_ready, 0);
      check_val("bp_hold", out_data, 8);
      cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_val("bp_release", prod_ready, 1);
    cycle();
    prod_valid = 1'b0;
    check_result("bp_second", 16, 0);
    cycle();

    // Asynchronous reset mid-vector.
    for (int i = 0; i < 3; i++) send_beat(22'd1000, 16'd0);
    #2;
    ap_rst = 1'b1;
    #1;
    check_val("arst_valid", out_valid, 0);
    check_val("arst_busy", busy, 0);
    cycle();
    ap_rst = 1'b0;
    cycle();
    send_const(16'd0, 22'd128);
    check_result("post_rst", 16, 0);
    cycle();

    // Randomized vectors with random gaps and random downstream backpressure.
    rdy_rand = 1'b1;
    for (int v = 0; v < 40; v++) begin
      logic [BIAS_W-1:0] b;
      b = BIAS_W'($urandom_range(0, 65535));
      for (int t = 0; t < N_TERMS; t++) begin
        logic [PROD_W-1:0] p;
        case ($urandom_range(0, 3))
          0:       p = '1;
          1:       p = PROD_W'($urandom_range(0, 255));
          default: p = PROD_W'($urandom_range(0, (1 << PROD_W) - 1));
        endcase
        send_beat(p, b);
        repeat ($urandom_range(0, 2)) cycle();
      end
    end

    rdy_rand  = 1'b0;
    out_ready = 1'b1;
    repeat (5) cycle();
    check_val("drain_results", exp_d.size(), 0);
    check_val("drain_terms", terms, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
